// File: rtl/pipeline_loop_pkg.sv
// Shared types and width helpers for the iterative loop controller family.
package pipeline_loop_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        OUTPUT = 2'd3
    } loopState_e;

    // Bits needed to hold an iteration index 0..iter, never narrower than 1.
    function automatic int iterCountWidth(input int iter);
        return (iter < 1) ? 1 : $clog2(iter + 1);
    endfunction

endpackage

// File: rtl/loop_counter.sv
// Iteration counter with synchronous clear, increment enable and last-iteration flag.
module loop_counter
    import pipeline_loop_pkg::*;
#(
    parameter int ITER = 256,
    parameter int CW   = iterCountWidth(ITER)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] count_o,
    output logic          last_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == CW'(ITER - 1));

endmodule

// File: rtl/pipeline_loop.sv
// Loop controller: takes one job, circulates it ITER times through an external
// body datapath, then offers the result and pulses a completion flag.
module pipeline_loop
    import pipeline_loop_pkg::*;
#(
    parameter int DWIDTH = 256,
    parameter int ITER   = 256,
    parameter int CW     = iterCountWidth(ITER)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [DWIDTH-1:0] i_data,
    output logic              o_body_valid,
    input  logic              i_body_ready,
    output logic [DWIDTH-1:0] o_body_data,
    output logic [CW-1:0]     o_iter,
    input  logic              i_body_valid,
    output logic              o_body_ready,
    input  logic [DWIDTH-1:0] i_body_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_complete
);

    loopState_e        state_q;
    logic [DWIDTH-1:0] data_q;
    logic              complete_q;
    logic [CW-1:0]     count;
    logic              lastIter;
    logic              cntClr;
    logic              cntInc;

    assign cntClr = (state_q == IDLE) && i_valid;
    assign cntInc = (state_q == WAIT) && i_body_valid && !lastIter;

    loop_counter #(
        .ITER (ITER),
        .CW   (CW)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cntClr),
        .inc_i   (cntInc),
        .count_o (count),
        .last_o  (lastIter)
    );

    // Data register carries no reset: its contents are meaningless outside a job.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            complete_q <= 1'b0;
        end else begin
            complete_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        data_q  <= i_data;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_body_ready) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_body_valid) begin
                        data_q  <= i_body_data;
                        state_q <= lastIter ? OUTPUT : ISSUE;
                    end
                end
                OUTPUT: begin
                    if (o_ready) begin
                        state_q    <= IDLE;
                        complete_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_ready      = (state_q == IDLE);
    assign o_body_valid = (state_q == ISSUE);
    assign o_body_data  = data_q;
    assign o_iter       = count;
    assign o_body_ready = (state_q == WAIT);
    assign o_valid      = (state_q == OUTPUT);
    assign o_data       = data_q;
    assign o_complete   = complete_q;

endmodule

// File: tb/tb_pipeline_loop.sv
// Directed bench for pipeline_loop: an ITER=4 instance with an increment body
// and an ITER=1 instance with an invert body share one set of stimulus inputs.
module tb_pipeline_loop;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          iValid;
    logic [DW-1:0] iData;
    logic          iBodyReady;
    logic          iBodyValid;
    logic          oReady;

    logic          iReady4, oBodyValid4, oBodyReady4, oValid4, oComplete4;
    logic [DW-1:0] oBodyData4, iBodyData4, oData4;
    logic [2:0]    oIter4;

    logic          iReady1, oBodyValid1, oBodyReady1, oValid1, oComplete1;
    logic [DW-1:0] oBodyData1, iBodyData1, oData1;
    logic [0:0]    oIter1;

    assign iBodyData4 = oBodyData4 + 8'd1;
    assign iBodyData1 = oBodyData1 ^ 8'hFF;

    pipeline_loop #(.DWIDTH(DW), .ITER(4)) dut4 (
        .clk(clk), .rst(rst),
        .i_valid(iValid), .i_ready(iReady4), .i_data(iData),
        .o_body_valid(oBodyValid4), .i_body_ready(iBodyReady),
        .o_body_data(oBodyData4), .o_iter(oIter4),
        .i_body_valid(iBodyValid), .o_body_ready(oBodyReady4), .i_body_data(iBodyData4),
        .o_valid(oValid4), .o_ready(oReady), .o_data(oData4), .o_complete(oComplete4)
    );

    pipeline_loop #(.DWIDTH(DW), .ITER(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_valid(iValid), .i_ready(iReady1), .i_data(iData),
        .o_body_valid(oBodyValid1), .i_body_ready(iBodyReady),
        .o_body_data(oBodyData1), .o_iter(oIter1),
        .i_body_valid(iBodyValid), .o_body_ready(oBodyReady1), .i_body_data(iBodyData1),
        .o_valid(oValid1), .o_ready(oReady), .o_data(oData1), .o_complete(oComplete1)
    );

    // Observation view of whichever instance the current test targets.
    logic          sel;
    logic          obsIReady, obsBodyValid, obsBodyReady, obsValid, obsComplete;
    logic [DW-1:0] obsBodyData, obsData;
    logic [2:0]    obsIter;

    assign obsIReady    = sel ? iReady1     : iReady4;
    assign obsBodyValid = sel ? oBodyValid1 : oBodyValid4;
    assign obsBodyReady = sel ? oBodyReady1 : oBodyReady4;
    assign obsValid     = sel ? oValid1     : oValid4;
    assign obsComplete  = sel ? oComplete1  : oComplete4;
    assign obsBodyData  = sel ? oBodyData1  : oBodyData4;
    assign obsData      = sel ? oData1      : oData4;
    assign obsIter      = sel ? {2'b00, oIter1} : oIter4;

    int checkCount = 0;
    int failCount  = 0;

    logic [DW-1:0] jobs[$];
    logic [DW-1:0] results[$];
    int            iterLog[$];
    int            accCycles[$];
    logic          accComplete[$];
    int            cyc, firstValid, issueCount, returnCount, completeCount;
    logic          prevBodyStall, prevOutStall;
    logic [DW-1:0] prevBodyData, prevOutData;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic clearLogs();
        jobs.delete(); results.delete(); iterLog.delete();
        accCycles.delete(); accComplete.delete();
        cyc = 0; firstValid = -1; issueCount = 0; returnCount = 0; completeCount = 0;
        prevBodyStall = 1'b0; prevOutStall = 1'b0;
        prevBodyData = '0; prevOutData = '0;
    endtask

    // Called at a negedge: holds reset over one rising edge and checks the reset state.
    task automatic doReset(input string tag);
        rst = 1'b1;
        iValid = 1'b0; iData = '0;
        iBodyReady = 1'b0; iBodyValid = 1'b0; oReady = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_i_ready"},      obsIReady,    1);
        checkOutput({tag, "_body_valid"},   obsBodyValid, 0);
        checkOutput({tag, "_body_ready"},   obsBodyReady, 0);
        checkOutput({tag, "_o_valid"},      obsValid,     0);
        checkOutput({tag, "_o_complete"},   obsComplete,  0);
        rst = 1'b0;
        clearLogs();
    endtask

    // mode 0: zero-wait body and sink; 1: random stalls everywhere;
    // 2: random i_body_ready with i_body_valid held high.
    task automatic applyStimulus(input int n, input int mode);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            case (mode)
                1: begin
                    iBodyReady = 1'($urandom_range(0, 1));
                    iBodyValid = 1'($urandom_range(0, 1));
                    oReady     = 1'($urandom_range(0, 1));
                end
                2: begin
                    iBodyReady = 1'($urandom_range(0, 1));
                    iBodyValid = 1'b1;
                    oReady     = 1'b1;
                end
                default: begin
                    iBodyReady = 1'b1; iBodyValid = 1'b1; oReady = 1'b1;
                end
            endcase
            if (jobs.size() > 0) begin
                iValid = 1'b1; iData = jobs[0];
            end else begin
                iValid = 1'b0;
            end
            #1;
            if (iValid && obsIReady) begin
                accCycles.push_back(cyc);
                accComplete.push_back(obsComplete);
                void'(jobs.pop_front());
            end
            if (prevBodyStall) begin
                checkOutput("body_valid_hold", obsBodyValid, 1);
                checkOutput("body_data_hold",  obsBodyData,  prevBodyData);
            end
            if (obsBodyValid && iBodyReady) begin
                iterLog.push_back(int'(obsIter));
                issueCount++;
            end
            prevBodyStall = obsBodyValid && !iBodyReady;
            prevBodyData  = obsBodyData;
            if (obsBodyReady && iBodyValid) returnCount++;
            if (prevOutStall) begin
                checkOutput("o_valid_hold", obsValid, 1);
                checkOutput("o_data_hold",  obsData,  prevOutData);
            end
            if (obsValid && firstValid < 0) firstValid = cyc;
            if (obsValid && oReady) results.push_back(obsData);
            prevOutStall = obsValid && !oReady;
            prevOutData  = obsData;
            if (obsComplete) completeCount++;
            cyc++;
        end
    endtask

    initial begin
        sel = 1'b0;
        clearLogs();
        doReset("reset");

        // Zero-wait body, ITER=4, job 0x10 -> four increments.
        jobs.push_back(8'h10);
        applyStimulus(20, 0);
        checkOutput("iter4_issues", issueCount, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < iterLog.size()) checkOutput($sformatf("iter4_o_iter%0d", i), iterLog[i], i);
        end
        checkOutput("iter4_results", results.size(), 1);
        if (results.size() > 0) checkOutput("iter4_o_data", results[0], 8'h14);
        checkOutput("iter4_valid_cycle", firstValid, 9);
        checkOutput("iter4_completes", completeCount, 1);

        // ITER=1 with an invert body: one pass, result at cycle 3.
        sel = 1'b1;
        @(negedge clk);
        doReset("reset1");
        jobs.push_back(8'hA5);
        applyStimulus(10, 0);
        checkOutput("iter1_issues", issueCount, 1);
        checkOutput("iter1_returns", returnCount, 1);
        checkOutput("iter1_results", results.size(), 1);
        if (results.size() > 0) checkOutput("iter1_o_data", results[0], 8'h5A);
        checkOutput("iter1_valid_cycle", firstValid, 3);

        // Random stalls on all three handshakes.
        sel = 1'b0;
        @(negedge clk);
        doReset("reset2");
        jobs.push_back(8'h10);
        applyStimulus(300, 1);
        checkOutput("stall_issues", issueCount, 4);
        checkOutput("stall_results", results.size(), 1);
        if (results.size() > 0) checkOutput("stall_o_data", results[0], 8'h14);
        checkOutput("stall_completes", completeCount, 1);

        // Back-to-back jobs with i_valid held high across both.
        @(negedge clk);
        doReset("reset3");
        jobs.push_back(8'h01);
        jobs.push_back(8'h20);
        applyStimulus(30, 0);
        checkOutput("b2b_accepts", accCycles.size(), 2);
        if (accCycles.size() == 2) begin
            checkOutput("b2b_accept2_cycle", accCycles[1], 10);
            checkOutput("b2b_accept2_complete", accComplete[1], 1);
        end
        checkOutput("b2b_results", results.size(), 2);
        if (results.size() == 2) begin
            checkOutput("b2b_result0", results[0], 8'h05);
            checkOutput("b2b_result1", results[1], 8'h24);
        end
        checkOutput("b2b_completes", completeCount, 2);

        // i_body_valid held high: only WAIT-cycle returns may count.
        @(negedge clk);
        doReset("reset4");
        jobs.push_back(8'h10);
        applyStimulus(100, 2);
        checkOutput("bv_high_issues", issueCount, 4);
        checkOutput("bv_high_returns", returnCount, 4);
        checkOutput("bv_high_results", results.size(), 1);
        if (results.size() > 0) checkOutput("bv_high_o_data", results[0], 8'h14);

        // Reset during WAIT of iteration 3.
        @(negedge clk);
        doReset("reset5");
        jobs.push_back(8'h10);
        applyStimulus(8, 0);
        @(negedge clk);
        checkOutput("midjob_in_wait", obsBodyReady, 1);
        checkOutput("midjob_iter", obsIter, 3);
        doReset("midjob_reset");
        applyStimulus(5, 0);
        checkOutput("midjob_no_result", results.size(), 0);
        checkOutput("midjob_no_complete", completeCount, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
